// File: rtl/hwpe_ctrl_regfile_ctx_fpga_pkg.sv
// Shared types for the multi-context register file: context index and job-queue status.
package hwpe_ctrl_fpga_package;

  // Wide enough for up to 256 contexts; users slice down to their own CTX_W.
  localparam int CTX_W_MAX = 8;

  typedef logic [CTX_W_MAX-1:0] ctx_idx_t;

  typedef struct packed {
    ctx_idx_t             running_ctx;
    ctx_idx_t             offload_ctx;
    logic [CTX_W_MAX:0]   nb_pending;
    logic                 running_valid;
  } ctx_queue_status_t;

endpackage

// File: rtl/hwpe_ctrl_regfile_ctx_fpga_if.sv
// Register-file access bus: word-addressed read port and byte-enabled write port.
interface hwpe_ctrl_regfile_ctx_fpga_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  localparam int NUM_BYTE = DATA_WIDTH / 8;

  logic                         ReadEnable;
  logic [ADDR_WIDTH-1:0]        ReadAddr;
  logic [DATA_WIDTH-1:0]        ReadData;
  logic                         ReadValid;
  logic                         WriteEnable;
  logic [ADDR_WIDTH-1:0]        WriteAddr;
  logic [NUM_BYTE-1:0][7:0]     WriteData;
  logic [NUM_BYTE-1:0]          WriteBE;

  modport master (
    output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBE,
    input  ReadData, ReadValid
  );

  modport slave (
    input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBE,
    output ReadData, ReadValid
  );
endinterface

// File: rtl/hwpe_ctrl_regfile_ctx_fpga_ctx_queue.sv
// Job queue over NB_CTX contexts: offload (producer) and running (consumer) pointers plus occupancy.
module hwpe_ctrl_ctx_queue_fpga
  import hwpe_ctrl_fpga_package::*;
#(
  parameter int NB_CTX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              commit,
  input  logic              job_done,
  output ctx_queue_status_t status,
  output logic              full,
  output logic              commit_err
);
  localparam int CTX_W = $clog2(NB_CTX);
  localparam logic [CTX_W:0]   FULL_CNT = (CTX_W+1)'(NB_CTX);
  localparam logic [CTX_W:0]   CNT_ONE  = (CTX_W+1)'(1);
  localparam logic [CTX_W-1:0] PTR_ONE  = CTX_W'(1);

  logic [CTX_W-1:0] run_ptr;
  logic [CTX_W-1:0] off_ptr;
  logic [CTX_W:0]   cnt;
  logic             commit_ok;
  logic             done_ok;

  assign full      = (cnt == FULL_CNT);
  // A retire in the same cycle frees the slot a full-queue commit needs.
  assign commit_ok = commit & (~full | job_done);
  assign done_ok   = job_done & (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      run_ptr    <= '0;
      off_ptr    <= '0;
      cnt        <= '0;
      commit_err <= 1'b0;
    end else begin
      commit_err <= commit & ~commit_ok;
      if (commit_ok) off_ptr <= off_ptr + PTR_ONE;
      if (done_ok)   run_ptr <= run_ptr + PTR_ONE;
      if (commit_ok && !done_ok)      cnt <= cnt + CNT_ONE;
      else if (done_ok && !commit_ok) cnt <= cnt - CNT_ONE;
    end
  end

  always_comb begin
    status               = '0;
    status.running_ctx   = ctx_idx_t'(run_ptr);
    status.offload_ctx   = ctx_idx_t'(off_ptr);
    status.nb_pending    = (CTX_W_MAX+1)'(cnt);
    status.running_valid = (cnt != '0);
  end
endmodule

// File: rtl/hwpe_ctrl_regfile_ctx_fpga.sv
// Multi-context flip-flop register file: host writes/reads the offload context, engine sees the running one.
module hwpe_ctrl_regfile_ctx_fpga
  import hwpe_ctrl_fpga_package::*;
#(
  parameter int  ADDR_WIDTH = 5,
  parameter int  DATA_WIDTH = 32,
  parameter int  NB_CTX     = 2,
  localparam int NUM_WORDS  = 2**ADDR_WIDTH,
  localparam int NUM_BYTE   = DATA_WIDTH / 8,
  localparam int CTX_W      = $clog2(NB_CTX)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  hwpe_ctrl_regfile_ctx_fpga_if.slave         bus,
  input  logic                                commit,
  input  logic                                job_done,
  output logic                                commit_err,
  output logic                                write_err,
  output logic                                running_valid,
  output logic [CTX_W-1:0]                    running_ctx,
  output logic [CTX_W-1:0]                    offload_ctx,
  output logic [CTX_W:0]                      nb_pending,
  output logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] MemContent
);
  ctx_queue_status_t       status;
  logic                    full;
  logic                    wr_ok;
  logic [NUM_BYTE-1:0][7:0] mem [NB_CTX][NUM_WORDS];
  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   rdata_p1;

  hwpe_ctrl_ctx_queue_fpga #(
    .NB_CTX (NB_CTX)
  ) i_queue (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .commit     (commit),
    .job_done   (job_done),
    .status     (status),
    .full       (full),
    .commit_err (commit_err)
  );

  assign running_ctx   = CTX_W'(status.running_ctx);
  assign offload_ctx   = CTX_W'(status.offload_ctx);
  assign nb_pending    = (CTX_W+1)'(status.nb_pending);
  assign running_valid = status.running_valid;

  // Writes are dropped while every context is queued, even if one retires this cycle.
  assign wr_ok = bus.WriteEnable & ~full;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int c = 0; c < NB_CTX; c++)
        for (int w = 0; w < NUM_WORDS; w++)
          mem[c][w] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NUM_BYTE; b++)
        if (bus.WriteBE[b]) mem[offload_ctx][bus.WriteAddr][b] <= bus.WriteData[b];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vld_p1    <= 1'b0;
      write_err <= 1'b0;
    end else begin
      vld_p1    <= bus.ReadEnable;
      write_err <= bus.WriteEnable & full;
    end
  end

  // p0 -> p1: data captured at the request edge, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (bus.ReadEnable) rdata_p1 <= mem[offload_ctx][bus.ReadAddr];
  end

  assign bus.ReadValid = vld_p1;
  assign bus.ReadData  = vld_p1 ? rdata_p1 : '0;

  always_comb begin
    MemContent = '0;
    for (int w = 0; w < NUM_WORDS; w++)
      MemContent[w] = mem[running_ctx][w];
  end
endmodule

// File: tb/tb_hwpe_ctrl_regfile_ctx_fpga.sv
// Directed bench for the multi-context register file (NB_CTX=2, 32 words x 32 bits).
module tb_hwpe_ctrl_regfile_ctx_fpga;
  logic              clk;
  logic              rst;
  logic              clear;
  logic              commit;
  logic              job_done;
  logic              commit_err;
  logic              write_err;
  logic              running_valid;
  logic [0:0]        running_ctx;
  logic [0:0]        offload_ctx;
  logic [1:0]        nb_pending;
  logic [31:0][31:0] MemContent;

  int compared   = 0;
  int mismatched = 0;

  hwpe_ctrl_regfile_ctx_fpga_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  hwpe_ctrl_regfile_ctx_fpga #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .NB_CTX     (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .bus           (bus),
    .commit        (commit),
    .job_done      (job_done),
    .commit_err    (commit_err),
    .write_err     (write_err),
    .running_valid (running_valid),
    .running_ctx   (running_ctx),
    .offload_ctx   (offload_ctx),
    .nb_pending    (nb_pending),
    .MemContent    (MemContent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; commit = 0; job_done = 0;
    bus.ReadEnable = 0; bus.ReadAddr = '0;
    bus.WriteEnable = 0; bus.WriteAddr = '0; bus.WriteData = '0; bus.WriteBE = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.WriteEnable = 1; bus.WriteAddr = a; bus.WriteData = d; bus.WriteBE = be;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; bus.WriteEnable = 1; bus.WriteAddr = 5'd1; bus.WriteData = 32'hFFFF_FFFF;
    bus.WriteBE = 4'hF; bus.ReadEnable = 1; commit = 1;
    tick(); tick();
    compared++; if (nb_pending !== 2'd0) begin mismatched++; $display("FAIL reset_nb_pending got %0d want 0", nb_pending); end
    compared++; if (running_valid !== 1'b0) begin mismatched++; $display("FAIL reset_running_valid got %b want 0", running_valid); end
    compared++; if ({running_ctx, offload_ctx} !== 2'b00) begin mismatched++; $display("FAIL reset_ptrs got %b want 00", {running_ctx, offload_ctx}); end
    compared++; if (bus.ReadValid !== 1'b0 || bus.ReadData !== 32'h0) begin mismatched++; $display("FAIL reset_read got v=%b d=%h want v=0 d=0", bus.ReadValid, bus.ReadData); end
    compared++; if ({commit_err, write_err} !== 2'b00) begin mismatched++; $display("FAIL reset_errs got %b want 00", {commit_err, write_err}); end
    compared++; if (MemContent !== '0) begin mismatched++; $display("FAIL reset_mem got word1=%h want all zero", MemContent[1]); end
    rst = 0; idle();
  endtask

  task automatic test_write_read();
    do_reset();
    wr(5'd3, 32'hDEAD_BEEF, 4'b0101); tick();
    bus.WriteEnable = 0; bus.ReadEnable = 1; bus.ReadAddr = 5'd3;
    compared++; if (bus.ReadValid !== 1'b0) begin mismatched++; $display("FAIL read_latency_early got v=%b want 0", bus.ReadValid); end
    tick();
    compared++; if (bus.ReadValid !== 1'b1) begin mismatched++; $display("FAIL read_valid got %b want 1", bus.ReadValid); end
    compared++; if (bus.ReadData !== 32'h00AD_00EF) begin mismatched++; $display("FAIL read_be_data got %h want 00ad00ef", bus.ReadData); end
    compared++; if (MemContent[3] !== 32'h00AD_00EF) begin mismatched++; $display("FAIL memcontent_w3 got %h want 00ad00ef", MemContent[3]); end
    bus.ReadEnable = 0; tick();
    compared++; if (bus.ReadValid !== 1'b0 || bus.ReadData !== 32'h0) begin mismatched++; $display("FAIL read_idle got v=%b d=%h want v=0 d=0", bus.ReadValid, bus.ReadData); end
    wr(5'd5, 32'h1234_5678, 4'hF); tick();
    wr(5'd5, 32'hCAFE_F00D, 4'hF); bus.ReadEnable = 1; bus.ReadAddr = 5'd5; tick();
    compared++; if (bus.ReadData !== 32'h1234_5678) begin mismatched++; $display("FAIL read_during_write got %h want 12345678", bus.ReadData); end
    bus.WriteEnable = 0; tick();
    compared++; if (bus.ReadData !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL read_after_write got %h want cafef00d", bus.ReadData); end
    idle();
  endtask

  task automatic test_queue_full();
    do_reset();
    commit = 1; tick();
    compared++; if (nb_pending !== 2'd1 || offload_ctx !== 1'b1) begin mismatched++; $display("FAIL commit1 got nb=%0d off=%0d want nb=1 off=1", nb_pending, offload_ctx); end
    compared++; if (running_valid !== 1'b1) begin mismatched++; $display("FAIL commit1_valid got %b want 1", running_valid); end
    tick();
    compared++; if (nb_pending !== 2'd2 || offload_ctx !== 1'b0 || commit_err !== 1'b0) begin mismatched++; $display("FAIL commit2 got nb=%0d off=%0d err=%b want nb=2 off=0 err=0", nb_pending, offload_ctx, commit_err); end
    tick();
    compared++; if (nb_pending !== 2'd2 || offload_ctx !== 1'b0 || running_ctx !== 1'b0) begin mismatched++; $display("FAIL commit3_state got nb=%0d off=%0d run=%0d want 2/0/0", nb_pending, offload_ctx, running_ctx); end
    compared++; if (commit_err !== 1'b1) begin mismatched++; $display("FAIL commit3_err got %b want 1", commit_err); end
    commit = 0; wr(5'd7, 32'hFFFF_FFFF, 4'hF); tick();
    compared++; if (commit_err !== 1'b0 || write_err !== 1'b1) begin mismatched++; $display("FAIL full_write got cerr=%b werr=%b want 0 1", commit_err, write_err); end
    bus.WriteEnable = 0; bus.ReadEnable = 1; bus.ReadAddr = 5'd7; tick();
    compared++; if (write_err !== 1'b0) begin mismatched++; $display("FAIL werr_pulse got %b want 0", write_err); end
    compared++; if (bus.ReadValid !== 1'b1 || bus.ReadData !== 32'h0 || MemContent[7] !== 32'h0) begin mismatched++; $display("FAIL dropped_write got v=%b d=%h mc=%h want v=1 d=0 mc=0", bus.ReadValid, bus.ReadData, MemContent[7]); end
    bus.ReadEnable = 0;
  endtask

  task automatic test_commit_done_full();
    commit = 1; job_done = 1; tick();
    commit = 0; job_done = 0;
    compared++; if (commit_err !== 1'b0) begin mismatched++; $display("FAIL full_commit_done_err got %b want 0", commit_err); end
    compared++; if (running_ctx !== 1'b1 || offload_ctx !== 1'b1 || nb_pending !== 2'd2) begin mismatched++; $display("FAIL full_commit_done got run=%0d off=%0d nb=%0d want 1/1/2", running_ctx, offload_ctx, nb_pending); end
  endtask

  task automatic test_context_switch();
    do_reset();
    wr(5'd0, 32'h11, 4'hF); tick();
    wr(5'd1, 32'h55, 4'hF); commit = 1; tick();
    commit = 0; wr(5'd0, 32'h22, 4'hF); tick();
    bus.WriteEnable = 0;
    compared++; if (MemContent[0] !== 32'h11 || MemContent[1] !== 32'h55) begin mismatched++; $display("FAIL running_ctx0 got w0=%h w1=%h want 11 55", MemContent[0], MemContent[1]); end
    compared++; if (nb_pending !== 2'd1) begin mismatched++; $display("FAIL switch_nb got %0d want 1", nb_pending); end
    job_done = 1; tick(); job_done = 0;
    compared++; if (running_valid !== 1'b0 || running_ctx !== 1'b1) begin mismatched++; $display("FAIL retire got valid=%b run=%0d want 0 1", running_valid, running_ctx); end
    compared++; if (MemContent[0] !== 32'h22 || MemContent[1] !== 32'h0) begin mismatched++; $display("FAIL running_ctx1 got w0=%h w1=%h want 22 0", MemContent[0], MemContent[1]); end
  endtask

  task automatic test_done_empty();
    job_done = 1; tick(); job_done = 0;
    compared++; if (nb_pending !== 2'd0 || running_ctx !== 1'b1 || offload_ctx !== 1'b1 || running_valid !== 1'b0) begin mismatched++; $display("FAIL done_empty got nb=%0d run=%0d off=%0d v=%b want 0/1/1/0", nb_pending, running_ctx, offload_ctx, running_valid); end
    commit = 1; job_done = 1; tick(); commit = 0; job_done = 0;
    compared++; if (nb_pending !== 2'd1 || running_ctx !== 1'b1 || offload_ctx !== 1'b0) begin mismatched++; $display("FAIL both_empty got nb=%0d run=%0d off=%0d want 1/1/0", nb_pending, running_ctx, offload_ctx); end
    job_done = 1; tick(); job_done = 0;
    compared++; if (running_ctx !== 1'b0 || MemContent[0] !== 32'h11 || MemContent[1] !== 32'h55) begin mismatched++; $display("FAIL persist got run=%0d w0=%h w1=%h want 0 11 55", running_ctx, MemContent[0], MemContent[1]); end
  endtask

  task automatic test_clear();
    clear = 1; commit = 1; bus.ReadEnable = 1; bus.ReadAddr = 5'd0;
    wr(5'd2, 32'hAAAA_AAAA, 4'hF); tick();
    idle();
    compared++; if (nb_pending !== 2'd0 || running_ctx !== 1'b0 || offload_ctx !== 1'b0 || running_valid !== 1'b0) begin mismatched++; $display("FAIL clear_queue got nb=%0d run=%0d off=%0d v=%b want 0/0/0/0", nb_pending, running_ctx, offload_ctx, running_valid); end
    compared++; if (bus.ReadValid !== 1'b0 || bus.ReadData !== 32'h0) begin mismatched++; $display("FAIL clear_read got v=%b d=%h want 0 0", bus.ReadValid, bus.ReadData); end
    compared++; if (MemContent !== '0) begin mismatched++; $display("FAIL clear_mem got w0=%h w2=%h want 0", MemContent[0], MemContent[2]); end
    bus.ReadEnable = 1; bus.ReadAddr = 5'd2; tick(); bus.ReadEnable = 0;
    compared++; if (bus.ReadValid !== 1'b1 || bus.ReadData !== 32'h0) begin mismatched++; $display("FAIL clear_write_dropped got v=%b d=%h want 1 0", bus.ReadValid, bus.ReadData); end
    commit = 1; tick(); commit = 0; job_done = 1; tick(); job_done = 0;
    compared++; if (running_ctx !== 1'b1 || MemContent[0] !== 32'h0) begin mismatched++; $display("FAIL clear_ctx1 got run=%0d w0=%h want 1 0", running_ctx, MemContent[0]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      wr(5'(8 + i), 32'h1000_0000 + 32'(i), 4'hF); tick();
    end
    bus.WriteEnable = 0;
    for (int i = 0; i < 4; i++) begin
      bus.ReadEnable = 1; bus.ReadAddr = 5'(8 + i); tick();
      compared++; if (bus.ReadValid !== 1'b1 || bus.ReadData !== 32'h1000_0000 + 32'(i)) begin mismatched++; $display("FAIL b2b_read%0d got v=%b d=%h want 1 %h", i, bus.ReadValid, bus.ReadData, 32'h1000_0000 + 32'(i)); end
    end
    bus.ReadEnable = 0; tick();
    compared++; if (bus.ReadValid !== 1'b0 || MemContent[11] !== 32'h1000_0003) begin mismatched++; $display("FAIL b2b_end got v=%b mc=%h want 0 10000003", bus.ReadValid, MemContent[11]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_write_read();
    test_queue_full();
    test_commit_done_full();
    test_context_switch();
    test_done_empty();
    test_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
